// File: rtl/cpld_pkg.sv
// Shared constants for the badge CPLD LED port: register indices, bit
// positions and the shift-engine state encoding.
package cpld_pkg;

    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_TXDATA  = 2'd1;
    localparam logic [1:0] REG_STATUS  = 2'd2;
    localparam logic [1:0] REG_SCRATCH = 2'd3;

    localparam int CTRL_START_BIT  = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;
    localparam int CTRL_DIV_LSB    = 4;

    localparam int STAT_BUSY_BIT = 0;
    localparam int STAT_DONE_BIT = 1;
    localparam int STAT_OVR_BIT  = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } shift_state_e;

endpackage

// File: rtl/led_shifter.sv
// Serial engine that clocks one byte MSB-first into the LED driver chain,
// then pulses LATCH; state_o exposes the FSM for debug.
module led_shifter
    import cpld_pkg::*;
#(
    parameter int DIV_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [7:0]       data_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             sclk_o,
    output logic             sdata_o,
    output logic             latch_o,
    output shift_state_e     state_o
);

    localparam logic [DIV_W-1:0] CNT_ONE = 1;

    shift_state_e     state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       sh_q, sh_d;
    logic             sclk_q, sclk_d;
    logic             done_q, done_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            sh_q    <= 8'h00;
            sclk_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            sclk_q  <= sclk_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        sclk_d  = sclk_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_SHIFT;
                    sh_d    = data_i;
                    bit_d   = 3'd7;
                    cnt_d   = '0;
                    sclk_d  = 1'b0;
                    div_d   = div_i;
                end
            end
            ST_SHIFT: begin
                if (cnt_q == div_q) begin
                    cnt_d = '0;
                    // Data only moves on the falling SCLK edge, so it is stable at the rise.
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                        sh_d   = {sh_q[6:0], 1'b0};
                        if (bit_q == 3'd0) begin
                            state_d = ST_LATCH;
                        end else begin
                            bit_d = bit_q - 3'd1;
                        end
                    end else begin
                        sclk_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_LATCH: begin
                if (cnt_q == div_q) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy_o  = (state_q != ST_IDLE);
    assign done_o  = done_q;
    assign sclk_o  = sclk_q;
    assign sdata_o = (state_q == ST_SHIFT) & sh_q[7];
    assign latch_o = (state_q == ST_LATCH);
    assign state_o = state_q;

endmodule

// File: rtl/cpld_led_port.sv
// Bus slave and register bank for the LED shift port behind the GAL glue.
// Define CPLD_LED_IRQ_EN to implement CTRL.IRQ_EN and the irq output.
module cpld_led_port
    import cpld_pkg::*;
#(
    parameter int DIV_W = 4
) (
    input  logic       clk,
    input  logic       RESET,
    input  logic       CPLDCSb,
    input  logic       WEb,
    input  logic [1:0] A,
    input  logic [7:0] d_in,
    output logic [7:0] d_out,
    output logic       d_oe,
    output logic       SCLK,
    output logic       SDATA,
    output logic       LATCH,
    output logic       irq
);

    // Bus handshake: one write strobe on the first clk edge of a select
    // (CPLDCSb low after being high) with WEb low; reads are combinational.
    logic             cs_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic [7:0]       txdata_q, txdata_d;
    logic [7:0]       scratch_q, scratch_d;
    logic             done_q, done_d;
    logic             ovr_q, ovr_d;
    logic             irq_q, irq_d;
    logic             irq_en;

    logic             busy, done_pulse;
    shift_state_e     eng_state;
    logic             wr_stb, wr_ctrl, wr_tx, wr_stat, wr_scr;
    logic             start_req, start_go;
    logic [7:0]       rd_data;

    assign wr_stb    = !CPLDCSb && cs_q && !WEb;
    assign wr_ctrl   = wr_stb && (A == REG_CTRL);
    assign wr_tx     = wr_stb && (A == REG_TXDATA);
    assign wr_stat   = wr_stb && (A == REG_STATUS);
    assign wr_scr    = wr_stb && (A == REG_SCRATCH);
    assign start_req = wr_ctrl && d_in[CTRL_START_BIT];
    assign start_go  = start_req && !busy;

`ifdef CPLD_LED_IRQ_EN
    logic irq_en_q, irq_en_d;
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) irq_en_q <= 1'b0;
        else       irq_en_q <= irq_en_d;
    end
    assign irq_en_d = wr_ctrl ? d_in[CTRL_IRQ_EN_BIT] : irq_en_q;
    assign irq_en   = irq_en_q;
`else
    assign irq_en = 1'b0;
`endif

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            cs_q      <= 1'b1;
            div_q     <= '0;
            txdata_q  <= 8'h00;
            scratch_q <= 8'h00;
            done_q    <= 1'b0;
            ovr_q     <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            cs_q      <= CPLDCSb;
            div_q     <= div_d;
            txdata_q  <= txdata_d;
            scratch_q <= scratch_d;
            done_q    <= done_d;
            ovr_q     <= ovr_d;
            irq_q     <= irq_d;
        end
    end

    always_comb begin
        div_d     = wr_ctrl ? d_in[CTRL_DIV_LSB +: DIV_W] : div_q;
        txdata_d  = (wr_tx && !busy) ? d_in : txdata_q;
        scratch_d = wr_scr ? d_in : scratch_q;
        // Engine completion beats any clear; a new start beats a W1C.
        done_d = done_q;
        if (done_pulse) begin
            done_d = 1'b1;
        end else if (start_go) begin
            done_d = 1'b0;
        end else if (wr_stat && d_in[STAT_DONE_BIT]) begin
            done_d = 1'b0;
        end
        ovr_d = ovr_q;
        if ((start_req || wr_tx) && busy) begin
            ovr_d = 1'b1;
        end else if (wr_stat && d_in[STAT_OVR_BIT]) begin
            ovr_d = 1'b0;
        end
        irq_d = done_d & irq_en;
    end

    always_comb begin
        rd_data = 8'h00;
        case (A)
            REG_CTRL: begin
                rd_data[CTRL_IRQ_EN_BIT]          = irq_en;
                rd_data[CTRL_DIV_LSB +: DIV_W]    = div_q;
            end
            REG_TXDATA: rd_data = txdata_q;
            REG_STATUS: begin
                rd_data[STAT_BUSY_BIT] = (eng_state != ST_IDLE);
                rd_data[STAT_DONE_BIT] = done_q;
                rd_data[STAT_OVR_BIT]  = ovr_q;
            end
            default: rd_data = scratch_q;
        endcase
    end

    assign d_oe  = !CPLDCSb && WEb;
    assign d_out = d_oe ? rd_data : 8'h00;
    assign irq   = irq_q;

    led_shifter #(
        .DIV_W (DIV_W)
    ) u_shifter (
        .clk_i   (clk),
        .rst_i   (RESET),
        .start_i (start_go),
        .data_i  (txdata_q),
        .div_i   (div_d),
        .busy_o  (busy),
        .done_o  (done_pulse),
        .sclk_o  (SCLK),
        .sdata_o (SDATA),
        .latch_o (LATCH),
        .state_o (eng_state)
    );

endmodule

// File: tb/tb_cpld_led_port.sv
// Directed bench for cpld_led_port: bus reads checked through a scoreboard
// queue, serial pins checked by a pin monitor against expected bit queues.
module tb_cpld_led_port;
    import cpld_pkg::*;

`ifdef CPLD_LED_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic       clk;
    logic       RESET;
    logic       CPLDCSb;
    logic       WEb;
    logic [1:0] A;
    logic [7:0] d_in;
    logic [7:0] d_out;
    logic       d_oe;
    logic       SCLK;
    logic       SDATA;
    logic       LATCH;
    logic       irq;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    logic [1:0] exp_a_q[$];
    logic       exp_bit_q[$];
    int         exp_half = 1;

    cpld_led_port #(.DIV_W(4)) dut (
        .clk     (clk),
        .RESET   (RESET),
        .CPLDCSb (CPLDCSb),
        .WEb     (WEb),
        .A       (A),
        .d_in    (d_in),
        .d_out   (d_out),
        .d_oe    (d_oe),
        .SCLK    (SCLK),
        .SDATA   (SDATA),
        .LATCH   (LATCH),
        .irq     (irq)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic bus_write(input logic [1:0] addr, input logic [7:0] data, input int hold);
        @(posedge clk); #1;
        CPLDCSb = 1'b0;
        WEb     = 1'b0;
        A       = addr;
        d_in    = data;
        repeat (hold) @(posedge clk);
        #1;
        CPLDCSb = 1'b1;
        WEb     = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] addr, input logic [7:0] exp);
        @(posedge clk); #1;
        CPLDCSb = 1'b0;
        WEb     = 1'b1;
        A       = addr;
        exp_q.push_back(exp);
        exp_a_q.push_back(addr);
        @(posedge clk); #1;
        CPLDCSb = 1'b1;
    endtask

    task automatic poll_status(input int n);
        CPLDCSb = 1'b0;
        WEb     = 1'b1;
        A       = REG_STATUS;
        repeat (n) @(posedge clk);
        #1;
        CPLDCSb = 1'b1;
    endtask

    task automatic push_status(input int n, input logic [7:0] val);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(val);
            exp_a_q.push_back(REG_STATUS);
        end
    endtask

    task automatic push_bits(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) exp_bit_q.push_back(b[i]);
    endtask

    // scoreboard + pin monitor
    initial begin
        logic [7:0] e;
        logic [1:0] a;
        logic       eb;
        logic       sclk_prev;
        logic       sdata_prev;
        logic       latch_prev;
        int         sclk_run;
        int         latch_run;
        sclk_prev = 1'b0; sdata_prev = 1'b0; latch_prev = 1'b0;
        sclk_run = 0; latch_run = 0;
        forever begin
            @(negedge clk);
            if (RESET) begin
                sclk_prev  = SCLK;
                sdata_prev = SDATA;
                latch_prev = LATCH;
                sclk_run   = 0;
                latch_run  = 0;
            end else begin
                if (d_oe) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_read: d_oe high with A=%0d d_out=0x%02h, no read expected", A, d_out);
                    end else begin
                        e = exp_q.pop_front();
                        a = exp_a_q.pop_front();
                        check($sformatf("read_reg%0d", a), {24'h0, d_out}, {24'h0, e});
                    end
                end
                if (SCLK && !sclk_prev) begin
                    if (exp_bit_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_sclk: SCLK rose with SDATA=%0b, no bit expected", SDATA);
                    end else begin
                        eb = exp_bit_q.pop_front();
                        check("sdata_bit", {31'h0, SDATA}, {31'h0, eb});
                    end
                end
                if (SDATA != sdata_prev) check("sdata_changes_sclk_low", {31'h0, SCLK}, 32'h0);
                if (!SCLK && sclk_prev)  check("sclk_high_len", sclk_run, exp_half);
                if (!LATCH && latch_prev) check("latch_len", latch_run, exp_half);
                sclk_run   = SCLK  ? sclk_run + 1  : 0;
                latch_run  = LATCH ? latch_run + 1 : 0;
                sclk_prev  = SCLK;
                sdata_prev = SDATA;
                latch_prev = LATCH;
            end
        end
    end

    // directed stimulus
    initial begin
        RESET   = 1'b1;
        CPLDCSb = 1'b1;
        WEb     = 1'b1;
        A       = 2'd0;
        d_in    = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        RESET = 1'b0;

        // reset state
        check("rst_sclk",  {31'h0, SCLK},  32'h0);
        check("rst_sdata", {31'h0, SDATA}, 32'h0);
        check("rst_latch", {31'h0, LATCH}, 32'h0);
        check("rst_irq",   {31'h0, irq},   32'h0);
        check("rst_d_oe",  {31'h0, d_oe},  32'h0);
        for (int i = 0; i < 4; i++) bus_read(2'(i), 8'h00);

        // long select gives exactly one write
        bus_write(REG_SCRATCH, 8'hA5, 4);
        bus_read(REG_SCRATCH, 8'hA5);

        // DIV=0 transfer of 0xC3
        bus_write(REG_TXDATA, 8'hC3, 1);
        bus_read(REG_TXDATA, 8'hC3);
        exp_half = 1;
        push_bits(8'hC3);
        push_status(17, 8'h01);
        push_status(1, 8'h00);
        push_status(1, 8'h02);
        bus_write(REG_CTRL, 8'h03, 1);
        poll_status(19);
        check("irq_after_c3", {31'h0, irq}, {31'h0, IRQ_ON});
        bus_read(REG_CTRL, IRQ_ON ? 8'h02 : 8'h00);

        // DIV=3 transfer of 0x80, START held for 4 cycles
        bus_write(REG_TXDATA, 8'h80, 1);
        exp_half = 4;
        push_bits(8'h80);
        push_status(65, 8'h01);
        push_status(1, 8'h00);
        push_status(1, 8'h02);
        bus_write(REG_CTRL, 8'h33, 4);
        poll_status(67);
        check("irq_after_80", {31'h0, irq}, {31'h0, IRQ_ON});
        bus_read(REG_CTRL, IRQ_ON ? 8'h32 : 8'h30);

        // overrun: TXDATA and START writes while busy
        bus_write(REG_TXDATA, 8'h5A, 1);
        exp_half = 2;
        push_bits(8'h5A);
        bus_write(REG_CTRL, 8'h13, 1);
        bus_write(REG_TXDATA, 8'hFF, 1);
        bus_write(REG_CTRL, 8'h13, 1);
        bus_read(REG_STATUS, 8'h05);
        bus_read(REG_TXDATA, 8'h5A);
        repeat (40) @(posedge clk);
        #1;
        bus_read(REG_STATUS, 8'h06);
        check("irq_after_5a", {31'h0, irq}, {31'h0, IRQ_ON});
        bus_write(REG_STATUS, 8'h06, 1);
        check("irq_after_w1c", {31'h0, irq}, 32'h0);
        bus_read(REG_STATUS, 8'h00);

        // asynchronous reset in the middle of SHIFT
        bus_write(REG_TXDATA, 8'hFF, 1);
        exp_half = 4;
        push_bits(8'hFF);
        bus_write(REG_CTRL, 8'h31, 1);
        repeat (5) @(posedge clk);
        #1;
        check("pre_rst_sclk",  {31'h0, SCLK},  32'h1);
        check("pre_rst_sdata", {31'h0, SDATA}, 32'h1);
        RESET = 1'b1;
        #1;
        check("mid_rst_sclk",  {31'h0, SCLK},  32'h0);
        check("mid_rst_sdata", {31'h0, SDATA}, 32'h0);
        check("mid_rst_latch", {31'h0, LATCH}, 32'h0);
        check("mid_rst_irq",   {31'h0, irq},   32'h0);
        check("mid_rst_d_oe",  {31'h0, d_oe},  32'h0);
        exp_bit_q.delete();
        @(negedge clk);
        @(posedge clk);
        #1;
        RESET = 1'b0;
        bus_read(REG_STATUS, 8'h00);
        bus_read(REG_TXDATA, 8'h00);
        bus_read(REG_CTRL, 8'h00);

        // final report
        repeat (3) @(posedge clk);
        #1;
        check("read_queue_drained", exp_q.size(), 32'h0);
        check("bit_queue_drained", exp_bit_q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
